// File: rtl/reg_bank_sb.sv
// reg_bank_sb: register bank with an integrated write-back scoreboard.
// Sits between decode and execute: accepts one decoded instruction per cycle,
// returns two registered operands plus the pipelined destination, and stalls
// decode while any referenced register still has a write-back outstanding.
// Optional feature macro: REGBANK_BYPASS_EN (same-cycle write-back forwarding).
module reg_bank_sb #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_dec_valid,
  input  logic [ADDR_W-1:0]      i_dec_rs1,
  input  logic [ADDR_W-1:0]      i_dec_rs2,
  input  logic [ADDR_W-1:0]      i_dec_rd,
  input  logic                   i_dec_wr,
  output logic                   o_stall,
  output logic                   o_ex_valid,
  output logic [DATA_W-1:0]      o_rdata1,
  output logic [DATA_W-1:0]      o_rdata2,
  output logic [ADDR_W-1:0]      o_ex_rd,
  output logic                   o_ex_wr,
  input  logic                   i_wb_en,
  input  logic [ADDR_W-1:0]      i_wb_addr,
  input  logic [DATA_W-1:0]      i_wb_data,
  output logic [(2**ADDR_W)-1:0] o_busy
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs_r [DEPTH];
  logic [DEPTH-1:0]  busy_r;
  logic [DEPTH-1:0]  busy_nxt_s;

  logic              wb_ok_s;
  logic              hz_rs1_s;
  logic              hz_rs2_s;
  logic              hz_rd_s;
  logic              stall_s;
  logic              accept_s;
  logic [DATA_W-1:0] rd1_s;
  logic [DATA_W-1:0] rd2_s;
`ifdef REGBANK_BYPASS_EN
  logic              hit_rs1_s;
  logic              hit_rs2_s;
  logic              hit_rd_s;
`endif

  // Register 0 is hard-wired (never written, never busy) when ZERO_REG is set.
  function automatic logic is_exempt(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 32'sd0) && (a == {ADDR_W{1'b0}});
  endfunction

  // Hazard detection, stall/accept decision and operand selection.
  always_comb begin
    wb_ok_s = i_wb_en && !is_exempt(i_wb_addr);
`ifdef REGBANK_BYPASS_EN
    hit_rs1_s = wb_ok_s && (i_wb_addr == i_dec_rs1);
    hit_rs2_s = wb_ok_s && (i_wb_addr == i_dec_rs2);
    hit_rd_s  = wb_ok_s && (i_wb_addr == i_dec_rd);
    hz_rs1_s  = busy_r[i_dec_rs1] && !hit_rs1_s;
    hz_rs2_s  = busy_r[i_dec_rs2] && !hit_rs2_s;
    hz_rd_s   = busy_r[i_dec_rd]  && !hit_rd_s;
`else
    hz_rs1_s  = busy_r[i_dec_rs1];
    hz_rs2_s  = busy_r[i_dec_rs2];
    hz_rd_s   = busy_r[i_dec_rd];
`endif
    if (is_exempt(i_dec_rs1)) hz_rs1_s = 1'b0;
    else                      hz_rs1_s = hz_rs1_s;
    if (is_exempt(i_dec_rs2)) hz_rs2_s = 1'b0;
    else                      hz_rs2_s = hz_rs2_s;
    if (is_exempt(i_dec_rd))  hz_rd_s  = 1'b0;
    else                      hz_rd_s  = hz_rd_s;

    stall_s  = i_dec_valid && (hz_rs1_s || hz_rs2_s || (i_dec_wr && hz_rd_s));
    accept_s = i_dec_valid && !stall_s;

    // Operand 1: zero register, then forwarded write-back, then array content.
    if (is_exempt(i_dec_rs1)) rd1_s = {DATA_W{1'b0}};
`ifdef REGBANK_BYPASS_EN
    else if (hit_rs1_s)       rd1_s = i_wb_data;
`endif
    else                      rd1_s = regs_r[i_dec_rs1];

    if (is_exempt(i_dec_rs2)) rd2_s = {DATA_W{1'b0}};
`ifdef REGBANK_BYPASS_EN
    else if (hit_rs2_s)       rd2_s = i_wb_data;
`endif
    else                      rd2_s = regs_r[i_dec_rs2];

    // Scoreboard update: clear on write-back, then set on accept (set wins).
    busy_nxt_s = busy_r;
    if (wb_ok_s) busy_nxt_s[i_wb_addr] = 1'b0;
    else         busy_nxt_s = busy_nxt_s;
    if (accept_s && i_dec_wr && !is_exempt(i_dec_rd)) busy_nxt_s[i_dec_rd] = 1'b1;
    else                                               busy_nxt_s = busy_nxt_s;
  end

  assign o_stall = stall_s;
  assign o_busy  = busy_r;

  // Register array: index-valued reset, write-back commit.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int n = 0; n < DEPTH; n++) begin
        regs_r[n] <= DATA_W'(n);
      end
    end else if (wb_ok_s) begin
      regs_r[i_wb_addr] <= i_wb_data;
    end
  end

  // Scoreboard state.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      busy_r <= {DEPTH{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // Execute-stage outputs: load on accept, otherwise drop valid and hold data.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_ex_valid <= 1'b0;
      o_rdata1   <= {DATA_W{1'b0}};
      o_rdata2   <= {DATA_W{1'b0}};
      o_ex_rd    <= {ADDR_W{1'b0}};
      o_ex_wr    <= 1'b0;
    end else if (accept_s) begin
      o_ex_valid <= 1'b1;
      o_rdata1   <= rd1_s;
      o_rdata2   <= rd2_s;
      o_ex_rd    <= i_dec_rd;
      o_ex_wr    <= i_dec_wr;
    end else begin
      o_ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_bank_sb.sv
// Directed testbench for reg_bank_sb (DATA_W=8, ADDR_W=4, ZERO_REG=1).
// Expectations follow REGBANK_BYPASS_EN when it is defined for the build.
module tb_reg_bank_sb;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_dec_valid = 1'b0;
  logic [3:0]  i_dec_rs1 = 4'd0;
  logic [3:0]  i_dec_rs2 = 4'd0;
  logic [3:0]  i_dec_rd = 4'd0;
  logic        i_dec_wr = 1'b0;
  logic        o_stall;
  logic        o_ex_valid;
  logic [7:0]  o_rdata1;
  logic [7:0]  o_rdata2;
  logic [3:0]  o_ex_rd;
  logic        o_ex_wr;
  logic        i_wb_en = 1'b0;
  logic [3:0]  i_wb_addr = 4'd0;
  logic [7:0]  i_wb_data = 8'd0;
  logic [15:0] o_busy;

  int n_checks = 0;
  int n_fail = 0;

  reg_bank_sb #(.DATA_W(8), .ADDR_W(4), .ZERO_REG(1)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_dec_valid(i_dec_valid), .i_dec_rs1(i_dec_rs1), .i_dec_rs2(i_dec_rs2),
    .i_dec_rd(i_dec_rd), .i_dec_wr(i_dec_wr), .o_stall(o_stall),
    .o_ex_valid(o_ex_valid), .o_rdata1(o_rdata1), .o_rdata2(o_rdata2),
    .o_ex_rd(o_ex_rd), .o_ex_wr(o_ex_wr),
    .i_wb_en(i_wb_en), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_dec(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                         input logic [3:0] rd, input logic wr);
    i_dec_valid = v; i_dec_rs1 = rs1; i_dec_rs2 = rs2; i_dec_rd = rd; i_dec_wr = wr;
  endtask

  task automatic set_wb(input logic en, input logic [3:0] addr, input logic [7:0] data);
    i_wb_en = en; i_wb_addr = addr; i_wb_data = data;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (o_busy !== 16'h0000) begin n_fail++; $display("FAIL reset_busy: got %h want 0000", o_busy); end
    n_checks++; if (o_ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_ex_valid); end
    n_checks++; if (o_rdata1 !== 8'h00 || o_rdata2 !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h/%h want 00/00", o_rdata1, o_rdata2); end
    n_checks++; if (o_ex_rd !== 4'd0 || o_ex_wr !== 1'b0) begin n_fail++; $display("FAIL reset_exrd: got %h/%b want 0/0", o_ex_rd, o_ex_wr); end
    cyc(); cyc();
    i_reset = 1'b1;
    cyc();
  endtask

  task automatic test_readback();
    set_dec(1'b1, 4'd3, 4'd15, 4'd0, 1'b0);
    #1;
    n_checks++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL rb_stall: got %b want 0", o_stall); end
    cyc();
    set_dec(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    n_checks++; if (o_ex_valid !== 1'b1) begin n_fail++; $display("FAIL rb_valid: got %b want 1", o_ex_valid); end
    n_checks++; if (o_rdata1 !== 8'h03 || o_rdata2 !== 8'h0F) begin n_fail++; $display("FAIL rb_data: got %h/%h want 03/0f", o_rdata1, o_rdata2); end
    n_checks++; if (o_busy !== 16'h0000) begin n_fail++; $display("FAIL rb_busy: got %h want 0000", o_busy); end
    cyc();
    n_checks++; if (o_ex_valid !== 1'b0) begin n_fail++; $display("FAIL rb_pulse: got %b want 0", o_ex_valid); end
    n_checks++; if (o_rdata1 !== 8'h03) begin n_fail++; $display("FAIL rb_hold: got %h want 03", o_rdata1); end
  endtask

  task automatic test_raw();
    set_dec(1'b1, 4'd1, 4'd2, 4'd5, 1'b1);
    cyc();
    n_checks++; if (o_busy !== 16'h0020) begin n_fail++; $display("FAIL raw_busy_set: got %h want 0020", o_busy); end
    n_checks++; if (o_ex_rd !== 4'd5 || o_ex_wr !== 1'b1 || o_rdata1 !== 8'h01 || o_rdata2 !== 8'h02) begin
      n_fail++; $display("FAIL raw_first: got rd=%h wr=%b d=%h/%h want 5/1 01/02", o_ex_rd, o_ex_wr, o_rdata1, o_rdata2); end
    set_dec(1'b1, 4'd5, 4'd0, 4'd0, 1'b0);
    #1;
    n_checks++; if (o_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall: got %b want 1", o_stall); end
    cyc();
    n_checks++; if (o_stall !== 1'b1 || o_ex_valid !== 1'b0) begin n_fail++; $display("FAIL raw_stall_hold: got stall=%b valid=%b want 1/0", o_stall, o_ex_valid); end
    set_wb(1'b1, 4'd5, 8'hA5);
    #1;
`ifdef REGBANK_BYPASS_EN
    n_checks++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL raw_wb_stall: got %b want 0", o_stall); end
    cyc();
    set_wb(1'b0, 4'd0, 8'h00);
    set_dec(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
`else
    n_checks++; if (o_stall !== 1'b1) begin n_fail++; $display("FAIL raw_wb_stall: got %b want 1", o_stall); end
    cyc();
    set_wb(1'b0, 4'd0, 8'h00);
    #1;
    n_checks++; if (o_stall !== 1'b0 || o_ex_valid !== 1'b0) begin n_fail++; $display("FAIL raw_extra: got stall=%b valid=%b want 0/0", o_stall, o_ex_valid); end
    cyc();
    set_dec(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
`endif
    n_checks++; if (o_ex_valid !== 1'b1 || o_rdata1 !== 8'hA5) begin n_fail++; $display("FAIL raw_data: got valid=%b d=%h want 1/a5", o_ex_valid, o_rdata1); end
    n_checks++; if (o_busy !== 16'h0000) begin n_fail++; $display("FAIL raw_busy_clr: got %h want 0000", o_busy); end
    cyc();
  endtask

  task automatic test_waw();
    set_dec(1'b1, 4'd0, 4'd0, 4'd7, 1'b1);
    cyc();
    n_checks++; if (o_busy !== 16'h0080) begin n_fail++; $display("FAIL waw_busy: got %h want 0080", o_busy); end
    #1;
    n_checks++; if (o_stall !== 1'b1) begin n_fail++; $display("FAIL waw_stall: got %b want 1", o_stall); end
    cyc();
    n_checks++; if (o_busy !== 16'h0080 || o_ex_valid !== 1'b0) begin n_fail++; $display("FAIL waw_hold: got busy=%h valid=%b want 0080/0", o_busy, o_ex_valid); end
    set_wb(1'b1, 4'd7, 8'h77);
`ifdef REGBANK_BYPASS_EN
    cyc();
    set_wb(1'b0, 4'd0, 8'h00);
    set_dec(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
`else
    cyc();
    set_wb(1'b0, 4'd0, 8'h00);
    n_checks++; if (o_busy !== 16'h0000) begin n_fail++; $display("FAIL waw_gap: got %h want 0000", o_busy); end
    cyc();
    set_dec(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
`endif
    n_checks++; if (o_busy !== 16'h0080 || o_ex_valid !== 1'b1 || o_ex_rd !== 4'd7) begin
      n_fail++; $display("FAIL waw_second: got busy=%h valid=%b rd=%h want 0080/1/7", o_busy, o_ex_valid, o_ex_rd); end
    set_wb(1'b1, 4'd7, 8'h77);
    cyc();
    set_wb(1'b0, 4'd0, 8'h00);
    n_checks++; if (o_busy !== 16'h0000) begin n_fail++; $display("FAIL waw_clear: got %h want 0000", o_busy); end
  endtask

  task automatic test_zero_reg();
    set_wb(1'b1, 4'd0, 8'hFF);
    cyc();
    set_wb(1'b0, 4'd0, 8'h00);
    set_dec(1'b1, 4'd0, 4'd0, 4'd0, 1'b1);
    #1;
    n_checks++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL zero_stall: got %b want 0", o_stall); end
    cyc();
    n_checks++; if (o_busy !== 16'h0000 || o_ex_valid !== 1'b1) begin n_fail++; $display("FAIL zero_busy: got busy=%h valid=%b want 0000/1", o_busy, o_ex_valid); end
    set_dec(1'b1, 4'd0, 4'd0, 4'd0, 1'b0);
    #1;
    n_checks++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL zero_stall2: got %b want 0", o_stall); end
    cyc();
    set_dec(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    n_checks++; if (o_rdata1 !== 8'h00 || o_rdata2 !== 8'h00) begin n_fail++; $display("FAIL zero_read: got %h/%h want 00/00", o_rdata1, o_rdata2); end
  endtask

  task automatic test_set_clear();
    set_dec(1'b1, 4'd0, 4'd0, 4'd4, 1'b1);
    cyc();
    n_checks++; if (o_busy !== 16'h0010) begin n_fail++; $display("FAIL sc_busy: got %h want 0010", o_busy); end
    set_wb(1'b1, 4'd4, 8'h44);
    set_dec(1'b1, 4'd4, 4'd4, 4'd4, 1'b1);
    #1;
`ifdef REGBANK_BYPASS_EN
    n_checks++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL sc_stall: got %b want 0", o_stall); end
    cyc();
    set_wb(1'b0, 4'd0, 8'h00);
    set_dec(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
`else
    n_checks++; if (o_stall !== 1'b1) begin n_fail++; $display("FAIL sc_stall: got %b want 1", o_stall); end
    cyc();
    set_wb(1'b0, 4'd0, 8'h00);
    #1;
    n_checks++; if (o_stall !== 1'b0 || o_busy !== 16'h0000) begin n_fail++; $display("FAIL sc_gap: got stall=%b busy=%h want 0/0000", o_stall, o_busy); end
    cyc();
    set_dec(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
`endif
    n_checks++; if (o_busy !== 16'h0010) begin n_fail++; $display("FAIL sc_set_wins: got %h want 0010", o_busy); end
    n_checks++; if (o_rdata1 !== 8'h44 || o_rdata2 !== 8'h44) begin n_fail++; $display("FAIL sc_data: got %h/%h want 44/44", o_rdata1, o_rdata2); end
    set_wb(1'b1, 4'd4, 8'h3C);
    cyc();
    set_wb(1'b0, 4'd0, 8'h00);
    set_dec(1'b1, 4'd4, 4'd7, 4'd0, 1'b0);
    cyc();
    set_dec(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    n_checks++; if (o_rdata1 !== 8'h3C || o_rdata2 !== 8'h77) begin n_fail++; $display("FAIL sc_regs: got %h/%h want 3c/77", o_rdata1, o_rdata2); end
    n_checks++; if (o_busy !== 16'h0000) begin n_fail++; $display("FAIL sc_clear: got %h want 0000", o_busy); end
  endtask

  task automatic test_back_to_back();
    set_dec(1'b1, 4'd1, 4'd2, 4'd0, 1'b0);
    cyc();
    n_checks++; if (o_ex_valid !== 1'b1 || o_rdata1 !== 8'h01 || o_rdata2 !== 8'h02) begin n_fail++; $display("FAIL b2b_0: got %b %h/%h want 1 01/02", o_ex_valid, o_rdata1, o_rdata2); end
    set_dec(1'b1, 4'd3, 4'd3, 4'd0, 1'b0);
    cyc();
    n_checks++; if (o_ex_valid !== 1'b1 || o_rdata1 !== 8'h03 || o_rdata2 !== 8'h03) begin n_fail++; $display("FAIL b2b_1: got %b %h/%h want 1 03/03", o_ex_valid, o_rdata1, o_rdata2); end
    set_dec(1'b1, 4'd9, 4'd10, 4'd9, 1'b1);
    cyc();
    set_dec(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    n_checks++; if (o_ex_valid !== 1'b1 || o_rdata1 !== 8'h09 || o_rdata2 !== 8'h0A || o_ex_rd !== 4'd9) begin
      n_fail++; $display("FAIL b2b_2: got %b %h/%h rd=%h want 1 09/0a rd=9", o_ex_valid, o_rdata1, o_rdata2, o_ex_rd); end
    n_checks++; if (o_busy !== 16'h0200) begin n_fail++; $display("FAIL b2b_busy: got %h want 0200", o_busy); end
  endtask

  task automatic test_mid_reset();
    set_dec(1'b1, 4'd6, 4'd8, 4'd11, 1'b1);
    cyc();
    set_dec(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    n_checks++; if (o_busy !== 16'h0A00 || o_ex_valid !== 1'b1) begin n_fail++; $display("FAIL mr_pre: got busy=%h valid=%b want 0a00/1", o_busy, o_ex_valid); end
    set_wb(1'b1, 4'd12, 8'hEE);
    #2;
    i_reset = 1'b0;
    #1;
    n_checks++; if (o_busy !== 16'h0000 || o_ex_valid !== 1'b0) begin n_fail++; $display("FAIL mr_state: got busy=%h valid=%b want 0000/0", o_busy, o_ex_valid); end
    n_checks++; if (o_rdata1 !== 8'h00 || o_rdata2 !== 8'h00 || o_ex_rd !== 4'd0 || o_ex_wr !== 1'b0) begin
      n_fail++; $display("FAIL mr_outs: got %h/%h rd=%h wr=%b want zeros", o_rdata1, o_rdata2, o_ex_rd, o_ex_wr); end
    cyc();
    set_wb(1'b0, 4'd0, 8'h00);
    i_reset = 1'b1;
    set_dec(1'b1, 4'd5, 4'd4, 4'd0, 1'b0);
    cyc();
    n_checks++; if (o_rdata1 !== 8'h05 || o_rdata2 !== 8'h04) begin n_fail++; $display("FAIL mr_regs_a: got %h/%h want 05/04", o_rdata1, o_rdata2); end
    set_dec(1'b1, 4'd7, 4'd12, 4'd0, 1'b0);
    cyc();
    n_checks++; if (o_rdata1 !== 8'h07 || o_rdata2 !== 8'h0C) begin n_fail++; $display("FAIL mr_regs_b: got %h/%h want 07/0c", o_rdata1, o_rdata2); end
    set_dec(1'b1, 4'd9, 4'd11, 4'd0, 1'b0);
    #1;
    n_checks++; if (o_stall !== 1'b0) begin n_fail++; $display("FAIL mr_nostall: got %b want 0", o_stall); end
    cyc();
    set_dec(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_readback();
    test_raw();
    test_waw();
    test_zero_reg();
    test_set_clear();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
